// File: rtl/fmap_stream_packer_pkg.sv
// Shared CNN definitions: pixel width default, frame sizing helpers, packer state encoding
// and the flat (channel, row, column) -> word index mapping used by packer, pool and benches.
package fmap_stream_packer_pkg;

  localparam int unsigned DefaultDataWidth = 16;

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } packState_e;

  function automatic int unsigned totalPix(input int unsigned h, input int unsigned w,
                                           input int unsigned d);
    return h * w * d;
  endfunction

  // Keep the counter at least one bit wide so a 1-pixel frame still elaborates.
  function automatic int unsigned cntWidth(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // Raster order: channel-major, then row, column fastest.
  function automatic int unsigned flatIndex(input int unsigned d, input int unsigned r,
                                            input int unsigned c, input int unsigned h,
                                            input int unsigned w);
    return d * h * w + r * w + c;
  endfunction

endpackage

// File: rtl/fmap_stream_packer.sv
// Collects a raster-ordered pixel stream into a flat feature-map bank and hands the whole
// frame to the 2x2 pool stage over a frame-level valid/ready handshake.
module fmap_stream_packer
  import fmap_stream_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned InputH     = 28,
  parameter int unsigned InputW     = 28,
  parameter int unsigned Depth      = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [DATA_WIDTH-1:0]                     pix_in,
  input  logic                                      pix_valid,
  input  logic                                      pix_last,
  output logic                                      pix_ready,
  output logic [InputH*InputW*Depth*DATA_WIDTH-1:0] frame_out,
  output logic                                      frame_valid,
  input  logic                                      frame_ready,
  output logic                                      len_err
);

  localparam int unsigned Total = totalPix(InputH, InputW, Depth);
  localparam int unsigned CntW  = cntWidth(Total);
  localparam logic [CntW-1:0] LastIdx = CntW'(Total - 1);

  packState_e      stateQ, stateD;
  logic [CntW-1:0] pixCntQ, pixCntD;
  logic            pixReadyQ, pixReadyD;
  logic            frameValidQ, frameValidD;
  logic            lenErrQ, lenErrD;

  logic pixFire;
  logic atLast;

  // pix_ready is only ever high in FILL, so it alone qualifies the write.
  assign pixFire = pix_valid & pixReadyQ;
  assign atLast  = (pixCntQ == LastIdx);

  always_comb begin
    stateD      = stateQ;
    pixCntD     = pixCntQ;
    pixReadyD   = pixReadyQ;
    frameValidD = frameValidQ;
    lenErrD     = lenErrQ;

    unique case (stateQ)
      StFill: begin
        pixReadyD = 1'b1;
        if (pixFire) begin
          // pix_last is only a consistency check; the count alone closes the frame.
          if (pix_last != atLast) begin
            lenErrD = 1'b1;
          end
          if (atLast) begin
            stateD      = StHold;
            pixReadyD   = 1'b0;
            frameValidD = 1'b1;
            pixCntD     = '0;
          end else begin
            pixCntD = pixCntQ + CntW'(1);
          end
        end
      end
      StHold: begin
        pixReadyD = 1'b0;
        if (frameValidQ && frame_ready) begin
          stateD      = StFill;
          frameValidD = 1'b0;
          pixReadyD   = 1'b1;
        end
      end
      default: begin
        stateD = StFill;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ      <= StFill;
      pixCntQ     <= '0;
      pixReadyQ   <= 1'b0;
      frameValidQ <= 1'b0;
      lenErrQ     <= 1'b0;
    end else begin
      stateQ      <= stateD;
      pixCntQ     <= pixCntD;
      pixReadyQ   <= pixReadyD;
      frameValidQ <= frameValidD;
      lenErrQ     <= lenErrD;
    end
  end

  // One write-enabled register per frame word, selected by the running pixel count.
  for (genvar i = 0; i < Total; i++) begin : gen_word
    logic [DATA_WIDTH-1:0] wordQ;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wordQ <= '0;
      end else if (pixFire && (pixCntQ == CntW'(i))) begin
        wordQ <= pix_in;
      end
    end

    assign frame_out[i*DATA_WIDTH +: DATA_WIDTH] = wordQ;
  end

  assign pix_ready   = pixReadyQ;
  assign frame_valid = frameValidQ;
  assign len_err     = lenErrQ;

endmodule

// File: tb/tb_fmap_stream_packer.sv
// Directed/randomized bench for fmap_stream_packer on a 4x4x1 frame, checked every cycle
// against a transaction-level model of the frame buffer and handshakes.
module tb_fmap_stream_packer;
  import fmap_stream_packer_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned H     = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned D     = 1;
  localparam int          Total = H * W * D;
  localparam int unsigned FW    = Total * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_last;
  logic          pix_ready;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          frame_ready;
  logic          len_err;

  fmap_stream_packer #(
    .DATA_WIDTH(DW),
    .InputH    (H),
    .InputW    (W),
    .Depth     (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pixels accepted so far, the stored words, and handshake flags.
  logic [DW-1:0] mBuf [Total];
  int            mCnt;
  bit            mHold;
  bit            mReady;
  bit            mValid;
  bit            mErr;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] expFrame();
    logic [FW-1:0] f;
    int k;
    f = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        k = int'(flatIndex(0, r, c, H, W));
        f[k*DW +: DW] = mBuf[k];
      end
    end
    return f;
  endfunction

  task automatic modelReset();
    mCnt   = 0;
    mHold  = 1'b0;
    mReady = 1'b0;
    mValid = 1'b0;
    mErr   = 1'b0;
    for (int i = 0; i < Total; i++) mBuf[i] = '0;
  endtask

  // Check outputs at the falling edge, then drive inputs and advance the model over the
  // following rising edge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit fr);
    bit hs;
    bit wasLast;
    @(negedge clk);
    chk("pix_ready", FW'(pix_ready), FW'(mReady));
    chk("frame_valid", FW'(frame_valid), FW'(mValid));
    chk("len_err", FW'(len_err), FW'(mErr));
    if (!rst_n) chk("frame_out_reset", frame_out, '0);
    else if (mValid) chk("frame_out", frame_out, expFrame());
    pix_valid   = v;
    pix_in      = d;
    pix_last    = l;
    frame_ready = fr;
    if (rst_n) begin
      if (!mHold) begin
        hs      = v && mReady;
        wasLast = (mCnt == Total - 1);
        if (hs) begin
          mBuf[mCnt] = d;
          if (l != wasLast) mErr = 1'b1;
          if (wasLast) begin
            mHold  = 1'b1;
            mValid = 1'b1;
            mCnt   = 0;
          end else begin
            mCnt++;
          end
        end
        mReady = !(hs && wasLast);
      end else if (fr) begin
        mHold  = 1'b0;
        mValid = 1'b0;
        mReady = 1'b1;
      end
    end
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    repeat (n) cycle(1'b1, DW'($urandom), 1'b0, 1'b1);
    rst_n  = 1'b1;
    mReady = 1'b1;  // first rising edge after release raises pix_ready
  endtask

  // Stream n pixels. mode: 0 -> k+1, 1 -> 0xA000+k, 2 -> 0x0100+k, 3 -> random.
  task automatic sendFrame(input int n, input int mode, input int lastPos, input bit fr,
                           input bit throttle);
    int acc = 0;
    int t = 0;
    bit v;
    bit hs;
    int k;
    logic [DW-1:0] data;
    while (acc < n && t < 200) begin
      v = throttle ? ((t % 4 == 0) || (t % 4 == 3)) : 1'b1;
      k = mCnt;
      case (mode)
        0:       data = DW'(k + 1);
        1:       data = DW'(16'hA000 + k);
        2:       data = DW'(16'h0100 + k);
        default: data = DW'($urandom);
      endcase
      if (!v) data = DW'($urandom);
      hs = v && mReady && !mHold;
      cycle(v, data, v && (k == lastPos), fr);
      if (hs) acc++;
      t++;
    end
    chk("pixels_accepted", FW'(acc), FW'(n));
  endtask

  task automatic idle(input int n, input bit v, input bit fr);
    repeat (n) cycle(v, DW'($urandom), 1'($urandom), fr);
  endtask

  initial begin
    rst_n       = 1'b0;
    pix_in      = '0;
    pix_valid   = 1'b0;
    pix_last    = 1'b0;
    frame_ready = 1'b0;
    modelReset();
    doReset(3);

    // Single frame 1..16, continuous valid, consumer always ready.
    sendFrame(16, 0, Total - 1, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);
    chk("len_err_clean", FW'(len_err), FW'(0));

    // Backpressure: consumer stalls 10 cycles while junk pixels are offered.
    sendFrame(16, 3, Total - 1, 1'b0, 1'b0);
    idle(10, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);

    // Throttled valid pattern 1,0,0,1.
    sendFrame(16, 1, Total - 1, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b1);

    // Early pix_last on the 10th pixel; frame still closes after 16.
    sendFrame(16, 3, 9, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b1);
    chk("len_err_early_last", FW'(len_err), FW'(1));
    doReset(2);
    chk("len_err_cleared", FW'(len_err), FW'(0));

    // Missing pix_last on the 16th pixel.
    sendFrame(16, 3, -1, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b1);
    chk("len_err_missing_last", FW'(len_err), FW'(1));
    doReset(2);

    // Reset after 7 pixels, then a fresh full frame held for a few cycles.
    sendFrame(7, 3, Total - 1, 1'b0, 1'b0);
    doReset(3);
    sendFrame(16, 2, Total - 1, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b1);

    // Back-to-back frames with the consumer always ready.
    sendFrame(16, 3, Total - 1, 1'b1, 1'b0);
    sendFrame(16, 3, Total - 1, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);
    chk("len_err_final", FW'(len_err), FW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
